// File: rtl/scu_data_resp_burst_sched.sv
// scu_data_resp_burst_sched: round-robin picks one SCU MSHR holding a full line
// and serialises it as DATA_BURST_NUM beats on the shared L1D data channel.
// Latency: grant at T, first beat at T+1 (registered). Next grant can overlap the last beat.
// Backpressure: beats hold while beat_rdy_i is low; req_rdy_o only asserts in a grant window.
//
// Ports:
//   clk, rstn                 clock, async active-low reset
//   req_vld_i / req_rdy_o     per-requester line offer / one-hot grant
//   req_line_i/dst_i/cw_i     per-requester line, destination L1D, critical beat index
//   beat_*_o / beat_rdy_i     serialised beat channel (valid/ready, index, dst, src, last)
//   busy_o                    burst in progress
//
// Build option: define SCU_DATA_RESP_CWF_EN to start each burst at the critical
// beat (wrapping); otherwise every burst runs beat 0..DATA_BURST_NUM-1.

module scu_data_resp_burst_sched #(
  parameter int REQ_NUM             = 4,
  parameter int DATA_LINE_W         = 512,
  parameter int DATA_LENGTH_PER_PKG = 64,
  parameter int DATA_BURST_NUM      = DATA_LINE_W / DATA_LENGTH_PER_PKG,
  parameter int DATA_BURST_NUM_W    = (DATA_BURST_NUM > 1) ? $clog2(DATA_BURST_NUM) : 1,
  parameter int DST_ID_W            = 3,
  parameter int SRC_W               = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [REQ_NUM-1:0]                      req_vld_i,
  output logic [REQ_NUM-1:0]                      req_rdy_o,
  input  logic [REQ_NUM-1:0][DATA_LINE_W-1:0]     req_line_i,
  input  logic [REQ_NUM-1:0][DST_ID_W-1:0]        req_dst_i,
  input  logic [REQ_NUM-1:0][DATA_BURST_NUM_W-1:0] req_cw_i,
  output logic                                    beat_vld_o,
  input  logic                                    beat_rdy_i,
  output logic [DATA_LENGTH_PER_PKG-1:0]          beat_data_o,
  output logic [DATA_BURST_NUM_W-1:0]             beat_idx_o,
  output logic [DST_ID_W-1:0]                     beat_dst_o,
  output logic [SRC_W-1:0]                        beat_src_o,
  output logic                                    beat_last_o,
  output logic                                    busy_o
);

  typedef enum logic {IDLE, SEND} state_e;

  localparam logic [SRC_W:0]            REQ_NUM_C = (SRC_W+1)'(REQ_NUM);
  localparam logic [SRC_W-1:0]          LAST_REQ  = SRC_W'(REQ_NUM - 1);
  localparam logic [DATA_BURST_NUM_W-1:0] LAST_CNT = DATA_BURST_NUM_W'(DATA_BURST_NUM - 1);

  state_e                                           state_q, state_d;
  logic [DATA_BURST_NUM-1:0][DATA_LENGTH_PER_PKG-1:0] line_q, line_d;
  logic [DST_ID_W-1:0]                              dst_q, dst_d;
  logic [SRC_W-1:0]                                 src_q, src_d;
  logic [DATA_BURST_NUM_W-1:0]                      start_q, start_d;
  logic [DATA_BURST_NUM_W-1:0]                      cnt_q, cnt_d;
  logic [SRC_W-1:0]                                 rr_q, rr_d;

  logic                        send;
  logic                        beat_fire;
  logic                        last_beat;
  logic                        win;
  logic                        found;
  logic                        hs;
  logic [REQ_NUM-1:0]          gnt_oh;
  logic [SRC_W-1:0]            gnt_idx;
  logic [SRC_W:0]              cand_w;
  logic [DATA_BURST_NUM_W-1:0] idx;

  assign send      = (state_q == SEND);
  assign last_beat = (cnt_q == LAST_CNT);
  assign beat_fire = send & beat_rdy_i;
  assign idx       = start_q + cnt_q;   // wraps naturally in the index width

  // Cyclic first-set search starting at rr_q. The sum stays below 2*REQ_NUM,
  // so a single conditional subtract gives the modulo.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand_w  = '0;
    for (int i = 0; i < REQ_NUM; i++) begin
      cand_w = {1'b0, rr_q} + (SRC_W+1)'(i);
      if (cand_w >= REQ_NUM_C) cand_w = cand_w - REQ_NUM_C;
      if (!found && req_vld_i[cand_w[SRC_W-1:0]]) begin
        found   = 1'b1;
        gnt_idx = cand_w[SRC_W-1:0];
      end
    end
    if (found) gnt_oh[gnt_idx] = 1'b1;
  end

  // The window also opens on the accepted last beat so bursts chain without a bubble.
  // Gating with rstn keeps every output at 0 while reset is held.
  assign win       = rstn & (~send | (beat_fire & last_beat));
  assign req_rdy_o = win ? gnt_oh : '0;
  assign hs        = win & found;

`ifndef SCU_DATA_RESP_CWF_EN
  logic unused_cw;
  assign unused_cw = ^req_cw_i;
`endif

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    dst_d   = dst_q;
    src_d   = src_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;

    if (beat_fire) begin
      cnt_d = cnt_q + DATA_BURST_NUM_W'(1);
      if (last_beat) state_d = IDLE;
    end

    if (hs) begin
      line_d  = req_line_i[gnt_idx];
      dst_d   = req_dst_i[gnt_idx];
      src_d   = gnt_idx;
`ifdef SCU_DATA_RESP_CWF_EN
      start_d = req_cw_i[gnt_idx];
`else
      start_d = '0;
`endif
      cnt_d   = '0;
      rr_d    = (gnt_idx == LAST_REQ) ? '0 : gnt_idx + SRC_W'(1);
      state_d = SEND;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      line_q  <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      start_q <= '0;
      cnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      line_q  <= line_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
    end
  end

  // Beat outputs depend on registers only; zero outside a burst.
  assign beat_vld_o  = send;
  assign busy_o      = send;
  assign beat_data_o = send ? line_q[idx] : '0;
  assign beat_idx_o  = send ? idx : '0;
  assign beat_dst_o  = send ? dst_q : '0;
  assign beat_src_o  = send ? src_q : '0;
  assign beat_last_o = send & last_beat;

endmodule
